// File: rtl/pagerank_gather_arbiter.sv
// rtl/pagerank_gather_arbiter.sv - round-robin scatter arbiter and iteration sequencer for the PageRank accumulator
//
// Purpose:
//   Merges scatter updates from NUM_THREADS threads onto the accumulator's single
//   update port and walks each iteration through clear, scatter, drain and the
//   hand-off to the damping stage.
//
// Ports:
//   clock, reset_n                    clock and asynchronous active-low reset
//   start, num_iterations             run request and iteration count (sampled in IDLE/DONE)
//   req_valid/req_rank/req_dest       per-thread update beats
//   req_done                          per-thread end-of-scatter pulse
//   req_ready                         one-hot combinational grant
//   pagerank_enable/pagerank_ready    accumulator enable and beat valid
//   page_rank_scatter/dest_id         accumulator beat payload (one cycle after accept)
//   scatter_operation_complete        held while waiting for the accumulator to drain
//   nextIteration                     one-cycle accumulator clear
//   gather_operation_complete         accumulator has drained
//   iter_done/apply_ack               damping hand-off pulse and its acknowledge
//   iteration_count/busy/done         run progress
//   err_dest_oob                      sticky: an out-of-range destination was dropped

module pagerank_gather_arbiter #(
    parameter int NUM_THREADS    = 4,
    parameter int NODES_IN_GRAPH = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [7:0]                   num_iterations,
    input  logic [NUM_THREADS-1:0]       req_valid,
    input  logic [NUM_THREADS-1:0][63:0] req_rank,
    input  logic [NUM_THREADS-1:0][31:0] req_dest,
    input  logic [NUM_THREADS-1:0]       req_done,
    output logic [NUM_THREADS-1:0]       req_ready,
    output logic                         pagerank_enable,
    output logic                         pagerank_ready,
    output logic [63:0]                  page_rank_scatter,
    output logic [31:0]                  dest_id,
    output logic                         scatter_operation_complete,
    output logic                         nextIteration,
    input  logic                         gather_operation_complete,
    output logic                         iter_done,
    input  logic                         apply_ack,
    output logic [7:0]                   iteration_count,
    output logic                         busy,
    output logic                         done,
    output logic                         err_dest_oob
);

    localparam int PW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCATTER,
        S_DRAIN,
        S_ITER_END,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            ptr_q;
    logic [NUM_THREADS-1:0]   done_seen_q;
    logic                     beat_valid_q;
    logic [63:0]              beat_rank_q;
    logic [31:0]              beat_dest_q;
    logic [7:0]               iter_count_q;
    logic [7:0]               num_iter_q;
    logic                     err_q;
    logic                     enable_q;
    logic                     soc_q;
    logic                     next_iter_q;
    logic                     iter_done_q;
    logic                     busy_q;
    logic                     done_q;

    logic [NUM_THREADS-1:0]   eligible;
    logic [NUM_THREADS-1:0]   grant_oh;
    logic [PW-1:0]            grant_idx;
    logic [PW-1:0]            ptr_next;
    logic                     grant_any;
    logic [63:0]              sel_rank;
    logic [31:0]              sel_dest;
    logic                     dest_in_range;
    int                       search_idx;

    // Round-robin search starting at ptr_q. Threads that already signalled
    // req_done are masked for the rest of the iteration.
    always_comb begin
        eligible   = (state_q == S_SCATTER) ? (req_valid & ~done_seen_q) : '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        search_idx = 0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            search_idx = int'(ptr_q) + k;
            if (search_idx >= NUM_THREADS) begin
                search_idx = search_idx - NUM_THREADS;
            end
            if (!grant_any && eligible[search_idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(search_idx);
            end
        end
        grant_oh      = grant_any ? (NUM_THREADS'(1) << grant_idx) : '0;
        sel_rank      = req_rank[grant_idx];
        sel_dest      = req_dest[grant_idx];
        dest_in_range = (sel_dest < 32'(NODES_IN_GRAPH));
        ptr_next      = (grant_idx == PW'(NUM_THREADS - 1)) ? '0 : grant_idx + 1'b1;
    end

    assign req_ready = grant_oh;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_iterations == 8'd0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR:   state_d = S_SCATTER;
            S_SCATTER: begin
                // The last accepted beat must leave the beat register before
                // the accumulator is told scattering is complete.
                if ((&done_seen_q) && !beat_valid_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (gather_operation_complete) begin
                    state_d = S_ITER_END;
                end
            end
            S_ITER_END: begin
                // The accumulator holds its results until the damping stage
                // acknowledges; only then may the next CLEAR happen.
                if (apply_ack) begin
                    state_d = ((iter_count_q + 8'd1) == num_iter_q) ? S_DONE : S_CLEAR;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            done_seen_q  <= '0;
            beat_valid_q <= 1'b0;
            beat_rank_q  <= '0;
            beat_dest_q  <= '0;
            iter_count_q <= '0;
            num_iter_q   <= '0;
            err_q        <= 1'b0;
            enable_q     <= 1'b0;
            soc_q        <= 1'b0;
            next_iter_q  <= 1'b0;
            iter_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            // Registered outputs are decoded from the state being entered so
            // they line up with the state they describe.
            next_iter_q <= (state_d == S_CLEAR);
            enable_q    <= (state_d == S_SCATTER) || (state_d == S_DRAIN);
            soc_q       <= (state_d == S_DRAIN);
            iter_done_q <= (state_d == S_ITER_END) && (state_q != S_ITER_END);
            busy_q      <= (state_d == S_CLEAR) || (state_d == S_SCATTER) ||
                           (state_d == S_DRAIN) || (state_d == S_ITER_END);
            done_q      <= (state_d == S_DONE);

            if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
                iter_count_q <= '0;
                num_iter_q   <= num_iterations;
                if (num_iterations != 8'd0) begin
                    err_q <= 1'b0;
                end
            end

            if (state_q == S_CLEAR) begin
                done_seen_q <= '0;
            end else if (state_q == S_SCATTER) begin
                done_seen_q <= done_seen_q | req_done;
            end

            // Out-of-range beats are accepted (the thread must not stall) but
            // never reach the accumulator.
            beat_valid_q <= grant_any && dest_in_range;
            if (grant_any) begin
                ptr_q <= ptr_next;
                if (dest_in_range) begin
                    beat_rank_q <= sel_rank;
                    beat_dest_q <= sel_dest;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if ((state_q == S_ITER_END) && apply_ack) begin
                iter_count_q <= iter_count_q + 8'd1;
            end
        end
    end

    assign pagerank_enable            = enable_q;
    assign pagerank_ready             = beat_valid_q;
    assign page_rank_scatter          = beat_rank_q;
    assign dest_id                    = beat_dest_q;
    assign scatter_operation_complete = soc_q;
    assign nextIteration              = next_iter_q;
    assign iter_done                  = iter_done_q;
    assign iteration_count            = iter_count_q;
    assign busy                       = busy_q;
    assign done                       = done_q;
    assign err_dest_oob               = err_q;

endmodule

// File: tb/tb_pagerank_gather_arbiter.sv
// tb/tb_pagerank_gather_arbiter.sv - self-checking bench for pagerank_gather_arbiter

module tb_pagerank_gather_arbiter;

    localparam int T = 4;
    localparam int NODES = 32;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [7:0]         num_iterations;
    logic [T-1:0]       req_valid;
    logic [T-1:0][63:0] req_rank;
    logic [T-1:0][31:0] req_dest;
    logic [T-1:0]       req_done;
    logic [T-1:0]       req_ready;
    logic               pagerank_enable;
    logic               pagerank_ready;
    logic [63:0]        page_rank_scatter;
    logic [31:0]        dest_id;
    logic               scatter_operation_complete;
    logic               nextIteration;
    logic               gather_operation_complete;
    logic               iter_done;
    logic               apply_ack;
    logic [7:0]         iteration_count;
    logic               busy;
    logic               done;
    logic               err_dest_oob;

    pagerank_gather_arbiter #(.NUM_THREADS(T), .NODES_IN_GRAPH(NODES)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .num_iterations(num_iterations),
        .req_valid(req_valid), .req_rank(req_rank), .req_dest(req_dest), .req_done(req_done),
        .req_ready(req_ready), .pagerank_enable(pagerank_enable), .pagerank_ready(pagerank_ready),
        .page_rank_scatter(page_rank_scatter), .dest_id(dest_id),
        .scatter_operation_complete(scatter_operation_complete), .nextIteration(nextIteration),
        .gather_operation_complete(gather_operation_complete), .iter_done(iter_done),
        .apply_ack(apply_ack), .iteration_count(iteration_count), .busy(busy), .done(done),
        .err_dest_oob(err_dest_oob)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: arbitration pointer, threads finished this
    // iteration, the beat expected on the accumulator port next cycle.
    int           m_ptr = 0;
    logic [T-1:0] m_ds = '0;
    logic         m_err = 1'b0;
    int           m_count = 0;
    logic         exp_bv = 1'b0;
    logic [63:0]  exp_rank = '0;
    logic [31:0]  exp_dest = '0;

    logic [63:0]  stg_rank [T];
    logic [31:0]  stg_dest [T];

    int n_next_pulses = 0;
    int n_iterd_pulses = 0;
    always @(negedge clock) begin
        if (nextIteration === 1'b1) n_next_pulses++;
        if (iter_done === 1'b1) n_iterd_pulses++;
    end

    task automatic stage_random(input bit allow_oob);
        for (int i = 0; i < T; i++) begin
            stg_rank[i] = {$urandom, $urandom};
            if (allow_oob && ($urandom % 8 == 0)) stg_dest[i] = 32'(NODES) + ($urandom % 200);
            else stg_dest[i] = $urandom % NODES;
        end
    endtask

    // One SCATTER-phase cycle: check last cycle's beat, drive this cycle's
    // requests, check the grant, then advance the model.
    task automatic scatter_cycle(input logic [T-1:0] v, input logic [T-1:0] d);
        int g;
        logic [T-1:0] exp_rdy;
        @(negedge clock);
        n_checks++; if (pagerank_ready !== exp_bv) $display("FAIL beat_valid: got %0b want %0b", pagerank_ready, exp_bv); else n_pass++;
        if (exp_bv) begin
            n_checks++; if (dest_id !== exp_dest) $display("FAIL beat_dest: got %0h want %0h", dest_id, exp_dest); else n_pass++;
            n_checks++; if (page_rank_scatter !== exp_rank) $display("FAIL beat_rank: got %0h want %0h", page_rank_scatter, exp_rank); else n_pass++;
        end
        n_checks++; if (err_dest_oob !== m_err) $display("FAIL err_dest_oob: got %0b want %0b", err_dest_oob, m_err); else n_pass++;
        n_checks++; if (pagerank_enable !== 1'b1) $display("FAIL scatter_enable: got %0b want 1", pagerank_enable); else n_pass++;
        req_valid = v;
        req_done  = d;
        for (int i = 0; i < T; i++) begin
            req_rank[i] = stg_rank[i];
            req_dest[i] = stg_dest[i];
        end
        #1;
        g = -1;
        for (int k = 0; k < T; k++) begin
            int idx;
            idx = (m_ptr + k) % T;
            if (g < 0 && v[idx] && !m_ds[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        n_checks++; if (req_ready !== exp_rdy) $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy); else n_pass++;
        exp_bv = 1'b0;
        if (g >= 0) begin
            if (stg_dest[g] < 32'(NODES)) begin
                exp_bv   = 1'b1;
                exp_rank = stg_rank[g];
                exp_dest = stg_dest[g];
            end else begin
                m_err = 1'b1;
            end
            m_ptr = (g + 1) % T;
        end
        m_ds = m_ds | d;
    endtask

    task automatic start_run(input logic [7:0] n);
        @(negedge clock);
        start = 1'b1;
        num_iterations = n;
        @(negedge clock);
        start = 1'b0;
        m_count = 0;
        exp_bv = 1'b0;
        if (n == 8'd0) begin
            n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %0b want 1", done); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %0b want 0", busy); else n_pass++;
            n_checks++; if (nextIteration !== 1'b0) $display("FAIL zero_clear: got %0b want 0", nextIteration); else n_pass++;
        end else begin
            m_err = 1'b0;
            m_ds  = '0;
            n_checks++; if (nextIteration !== 1'b1) $display("FAIL start_clear: got %0b want 1", nextIteration); else n_pass++;
            n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL start_busy: got busy=%0b done=%0b want 1/0", busy, done); else n_pass++;
            n_checks++; if (err_dest_oob !== 1'b0) $display("FAIL start_err_clear: got %0b want 0", err_dest_oob); else n_pass++;
        end
        n_checks++; if (iteration_count !== 8'd0) $display("FAIL start_count: got %0d want 0", iteration_count); else n_pass++;
    endtask

    task automatic end_scatter();
        scatter_cycle('0, {T{1'b1}});
        scatter_cycle('0, '0);
        scatter_cycle('0, '0);
        for (int i = 0; i < 10 && scatter_operation_complete !== 1'b1; i++) @(negedge clock);
        n_checks++; if (scatter_operation_complete !== 1'b1) $display("FAIL drain_timeout: got %0b want 1", scatter_operation_complete); else n_pass++;
    endtask

    task automatic finish_iter(input int ack_delay, input bit last);
        gather_operation_complete = 1'b1;
        @(negedge clock);
        gather_operation_complete = 1'b0;
        n_checks++; if (iter_done !== 1'b1) $display("FAIL iter_done_pulse: got %0b want 1", iter_done); else n_pass++;
        n_checks++; if (pagerank_enable !== 1'b0 || scatter_operation_complete !== 1'b0) $display("FAIL iter_end_outputs: got en=%0b soc=%0b want 0/0", pagerank_enable, scatter_operation_complete); else n_pass++;
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clock);
            n_checks++; if (iter_done !== 1'b0 || nextIteration !== 1'b0) $display("FAIL hold_for_ack: got iter_done=%0b clear=%0b want 0/0", iter_done, nextIteration); else n_pass++;
        end
        apply_ack = 1'b1;
        @(negedge clock);
        apply_ack = 1'b0;
        m_count++;
        n_checks++; if (iteration_count !== 8'(m_count)) $display("FAIL iteration_count: got %0d want %0d", iteration_count, m_count); else n_pass++;
        if (last) begin
            n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL run_done: got done=%0b busy=%0b want 1/0", done, busy); else n_pass++;
        end else begin
            m_ds = '0;
            n_checks++; if (nextIteration !== 1'b1) $display("FAIL next_clear: got %0b want 1", nextIteration); else n_pass++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({req_ready, pagerank_enable, pagerank_ready, scatter_operation_complete, nextIteration,
             iter_done, busy, done, err_dest_oob} !== '0 || iteration_count !== 8'd0 ||
            page_rank_scatter !== 64'd0 || dest_id !== 32'd0)
            $display("FAIL %s: outputs not all zero rdy=%b en=%0b prdy=%0b busy=%0b done=%0b cnt=%0d dest=%0h", tag,
                     req_ready, pagerank_enable, pagerank_ready, busy, done, iteration_count, dest_id);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; num_iterations = '0; req_valid = '0; req_done = '0;
        req_rank = '0; req_dest = '0; gather_operation_complete = 1'b0; apply_ack = 1'b0;
        repeat (2) @(negedge clock);
        req_valid = '1;
        #1;
        check_all_zero("reset_state");
        req_valid = '0;
        reset_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_single_update();
        start_run(8'd1);
        stage_random(1'b0);
        stg_dest[0] = 32'd3;
        stg_rank[0] = 64'd5;
        scatter_cycle(4'b0001, '0);
        scatter_cycle('0, 4'b1110);
        n_checks++; if (pagerank_ready !== 1'b1 || dest_id !== 32'd3 || page_rank_scatter !== 64'd5) $display("FAIL single_beat: got v=%0b dest=%0d rank=%0d want 1/3/5", pagerank_ready, dest_id, page_rank_scatter); else n_pass++;
        end_scatter();
        finish_iter(1, 1'b1);
    endtask

    task automatic test_zero_iter();
        start_run(8'd0);
    endtask

    task automatic test_dest_oob();
        start_run(8'd1);
        stage_random(1'b0);
        stg_dest[2] = 32'd40;
        scatter_cycle(4'b0100, '0);
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL oob_accept: got %b want 0100", req_ready); else n_pass++;
        scatter_cycle('0, '0);
        n_checks++; if (pagerank_ready !== 1'b0 || err_dest_oob !== 1'b1) $display("FAIL oob_drop: got v=%0b err=%0b want 0/1", pagerank_ready, err_dest_oob); else n_pass++;
        end_scatter();
        finish_iter(0, 1'b1);
    endtask

    task automatic test_done_masks();
        start_run(8'd2);
        stage_random(1'b0);
        scatter_cycle('0, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            scatter_cycle(4'b0010, '0);
            n_checks++; if (req_ready[1] !== 1'b0) $display("FAIL done_mask: got %0b want 0", req_ready[1]); else n_pass++;
        end
        end_scatter();
        finish_iter(0, 1'b0);
        scatter_cycle(4'b0010, '0);
        n_checks++; if (req_ready[1] !== 1'b1) $display("FAIL done_unmask: got %0b want 1", req_ready[1]); else n_pass++;
        end_scatter();
        finish_iter(0, 1'b1);
    endtask

    task automatic test_multi_iter();
        n_next_pulses = 0;
        n_iterd_pulses = 0;
        start_run(8'd3);
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < 4; c++) begin
                stage_random(1'b0);
                scatter_cycle(4'($urandom), '0);
            end
            end_scatter();
            finish_iter(2, it == 2);
        end
        @(negedge clock);
        n_checks++; if (n_next_pulses != 3) $display("FAIL clear_pulses: got %0d want 3", n_next_pulses); else n_pass++;
        n_checks++; if (n_iterd_pulses != 3) $display("FAIL iter_done_pulses: got %0d want 3", n_iterd_pulses); else n_pass++;
        n_checks++; if (iteration_count !== 8'd3 || done !== 1'b1) $display("FAIL multi_final: got cnt=%0d done=%0b want 3/1", iteration_count, done); else n_pass++;
    endtask

    task automatic test_random();
        start_run(8'd3);
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < 25; c++) begin
                logic [T-1:0] d;
                d = '0;
                for (int i = 0; i < T; i++) d[i] = ($urandom % 12 == 0);
                stage_random(1'b1);
                scatter_cycle(4'($urandom), d);
            end
            end_scatter();
            finish_iter(int'($urandom % 4), it == 2);
        end
    endtask

    task automatic test_reset_mid_run();
        start_run(8'd2);
        stage_random(1'b0);
        scatter_cycle(4'b1111, '0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        @(negedge clock);
        reset_n = 1'b1;
        req_valid = '0;
        m_ptr = 0;
        exp_bv = 1'b0;
    endtask

    task automatic test_back_to_back();
        start_run(8'd1);
        for (int k = 0; k < 8; k++) begin
            logic [T-1:0] e;
            e = 4'b0001 << (k % T);
            stage_random(1'b0);
            scatter_cycle(4'b1111, '0);
            n_checks++; if (req_ready !== e) $display("FAIL b2b_grant%0d: got %b want %b", k, req_ready, e); else n_pass++;
        end
        end_scatter();
        finish_iter(1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_update();
        test_zero_iter();
        test_dest_oob();
        test_done_masks();
        test_multi_iter();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
